clock_alarm_core: RTL and testbench

CLOCK_ALARM_CORE -- requirements
Module: clock_alarm_core

---
 rtl/clock_alarm_core.sv | 196 +++++++++++++++++++
 tb/tb_clock_alarm_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_alarm_core.sv
// clock_alarm_core: BCD hh:mm:ss time-of-day counter with a one-second
// prescaler, validated time load and NUM_ALARMS sticky hh:mm alarm channels.
// Optional feature macro: CLOCK_ALARM_SNOOZE_EN adds the alm_snooze input,
// which re-fires a channel five minutes after it is snoozed.
module clock_alarm_core #(
    parameter int unsigned CLK_PER_SEC = 4,
    parameter int unsigned NUM_ALARMS  = 2
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              run,
    input  logic                                              set_valid,
    input  logic [23:0]                                       set_time,
    output logic                                              set_ready,
    output logic                                              set_err,
    input  logic                                              alm_wr,
    input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] alm_idx,
    input  logic [15:0]                                       alm_time,
    input  logic                                              alm_arm,
    input  logic [NUM_ALARMS-1:0]                             alm_ack,
`ifdef CLOCK_ALARM_SNOOZE_EN
    input  logic [NUM_ALARMS-1:0]                             alm_snooze,
`endif
    output logic [23:0]                                       time_out,
    output logic                                              sec_pulse,
    output logic [NUM_ALARMS-1:0]                             alm_irq
);

    localparam int unsigned AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int unsigned CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [23:0]             time_q;
    logic                    sec_pulse_q;
    logic                    set_err_q;
    logic [NUM_ALARMS-1:0]   irq_q;
    logic [15:0]             alm_time_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]   alm_arm_q;
`ifdef CLOCK_ALARM_SNOOZE_EN
    logic [15:0]             snz_time_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]   snz_pend_q;
    logic [NUM_ALARMS-1:0]   snz_hit_c;
`endif

    logic                    tick_c;
    logic                    set_ok_c;
    logic                    alm_ok_c;
    logic                    load_c;
    logic                    adv_c;
    logic [23:0]             time_inc_d;
    logic [NUM_ALARMS-1:0]   hit_c;

    // Increment one BCD byte whose low digit may carry into the high digit.
    function automatic logic [7:0] inc_bcd(input logic [7:0] v);
        return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
    endfunction

    // Legal BCD hh:mm (hours 00..23, minutes 00..59).
    function automatic logic hm_ok(input logic [15:0] v);
        return (((v[15:12] < 4'd2) && (v[11:8] <= 4'd9)) ||
                ((v[15:12] == 4'd2) && (v[11:8] <= 4'd3))) &&
               (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

`ifdef CLOCK_ALARM_SNOOZE_EN
    // hh:mm plus five minutes with BCD minute and 23:59 -> 00:0x wrap.
    function automatic logic [15:0] plus5(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] >= 4'd5) begin
            r[3:0] = v[3:0] - 4'd5;
            if (v[7:4] == 4'd5) begin
                r[7:4]  = 4'd0;
                r[15:8] = (v[15:8] == 8'h23) ? 8'h00 : inc_bcd(v[15:8]);
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd5;
        end
        return r;
    endfunction
`endif

    assign set_ready = rst_n;
    assign time_out  = time_q;
    assign sec_pulse = sec_pulse_q;
    assign set_err   = set_err_q;
    assign alm_irq   = irq_q;

    // Tick, load qualification, next time value and alarm matches.
    always_comb begin
        tick_c     = run && (cnt_q == CW'(CLK_PER_SEC - 1));
        set_ok_c   = hm_ok(set_time[23:8]) && (set_time[7:4] <= 4'd5) && (set_time[3:0] <= 4'd9);
        alm_ok_c   = hm_ok(alm_time);
        load_c     = set_valid && set_ok_c;
        adv_c      = tick_c && !load_c;
        time_inc_d = time_q;
        if (time_q[7:0] == 8'h59) begin
            time_inc_d[7:0] = 8'h00;
            if (time_q[15:8] == 8'h59) begin
                time_inc_d[15:8]  = 8'h00;
                time_inc_d[23:16] = (time_q[23:16] == 8'h23) ? 8'h00 : inc_bcd(time_q[23:16]);
            end else begin
                time_inc_d[15:8] = inc_bcd(time_q[15:8]);
            end
        end else begin
            time_inc_d[7:0] = inc_bcd(time_q[7:0]);
        end
        hit_c = '0;
`ifdef CLOCK_ALARM_SNOOZE_EN
        snz_hit_c = '0;
`endif
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            hit_c[i] = adv_c && (time_inc_d[7:0] == 8'h00) && alm_arm_q[i] &&
                       (time_inc_d[23:8] == alm_time_q[i]);
`ifdef CLOCK_ALARM_SNOOZE_EN
            snz_hit_c[i] = adv_c && (time_inc_d[7:0] == 8'h00) && snz_pend_q[i] &&
                           (time_inc_d[23:8] == snz_time_q[i]);
`endif
        end
    end

    // Run/hold state, prescaler, time, pulses and alarm channels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            time_q      <= 24'h000000;
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
            irq_q       <= '0;
            alm_arm_q   <= '0;
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                alm_time_q[i] <= 16'h0000;
`ifdef CLOCK_ALARM_SNOOZE_EN
                snz_time_q[i] <= 16'h0000;
`endif
            end
`ifdef CLOCK_ALARM_SNOOZE_EN
            snz_pend_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_HOLD: if (run)  state_q <= ST_RUN;
                ST_RUN:  if (!run) state_q <= ST_HOLD;
            endcase

            // A valid load restarts the second and swallows a coincident tick.
            if (load_c) begin
                time_q <= set_time;
                cnt_q  <= '0;
            end else if (run) begin
                cnt_q <= tick_c ? '0 : cnt_q + CW'(1);
                if (tick_c) time_q <= time_inc_d;
            end

            sec_pulse_q <= adv_c;
            set_err_q   <= (set_valid && !set_ok_c) || (alm_wr && !alm_ok_c);

            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                if (alm_wr && alm_ok_c && (alm_idx == AW'(i))) begin
                    alm_time_q[i] <= alm_time;
                    alm_arm_q[i]  <= alm_arm;
                    irq_q[i]      <= 1'b0;
`ifdef CLOCK_ALARM_SNOOZE_EN
                end else if (hit_c[i] || snz_hit_c[i]) begin
                    irq_q[i] <= 1'b1;
                end else if (alm_ack[i] || alm_snooze[i]) begin
                    irq_q[i] <= 1'b0;
                end
`else
                end else if (hit_c[i]) begin
                    irq_q[i] <= 1'b1;
                end else if (alm_ack[i]) begin
                    irq_q[i] <= 1'b0;
                end
`endif
`ifdef CLOCK_ALARM_SNOOZE_EN
                if ((alm_wr && alm_ok_c && (alm_idx == AW'(i))) || alm_ack[i]) begin
                    snz_pend_q[i] <= 1'b0;
                end else if (alm_snooze[i]) begin
                    snz_pend_q[i] <= 1'b1;
                    snz_time_q[i] <= plus5(time_q[23:8]);
                end else if (snz_hit_c[i]) begin
                    snz_pend_q[i] <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core (CLK_PER_SEC=4, NUM_ALARMS=2): each
// step pushes the expected post-edge outputs to a scoreboard and pops them
// for comparison one time unit after the rising edge.
module tb_clock_alarm_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        set_valid = 1'b0;
    logic [23:0] set_time = 24'h0;
    logic        set_ready;
    logic        set_err;
    logic        alm_wr = 1'b0;
    logic [0:0]  alm_idx = 1'b0;
    logic [15:0] alm_time = 16'h0;
    logic        alm_arm = 1'b0;
    logic [1:0]  alm_ack = 2'b00;
`ifdef CLOCK_ALARM_SNOOZE_EN
    logic [1:0]  alm_snooze = 2'b00;
`endif
    logic [23:0] time_out;
    logic        sec_pulse;
    logic [1:0]  alm_irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [23:0] t;
        logic        sp;
        logic        se;
        logic [1:0]  irq;
        logic        rdy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    clock_alarm_core #(.CLK_PER_SEC(4), .NUM_ALARMS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .set_valid (set_valid),
        .set_time  (set_time),
        .set_ready (set_ready),
        .set_err   (set_err),
        .alm_wr    (alm_wr),
        .alm_idx   (alm_idx),
        .alm_time  (alm_time),
        .alm_arm   (alm_arm),
        .alm_ack   (alm_ack),
`ifdef CLOCK_ALARM_SNOOZE_EN
        .alm_snooze(alm_snooze),
`endif
        .time_out  (time_out),
        .sec_pulse (sec_pulse),
        .alm_irq   (alm_irq)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: queue the expectation, let the edge pass, pop and compare.
    task automatic step(input string tag, input logic [23:0] t, input logic sp,
                        input logic se, input logic [1:0] irq, input logic rdy);
        exp_t e;
        e.tag = tag; e.t = t; e.sp = sp; e.se = se; e.irq = irq; e.rdy = rdy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".time"},  time_out,          e.t);
        chk({e.tag, ".sec"},   24'(sec_pulse),    24'(e.sp));
        chk({e.tag, ".err"},   24'(set_err),      24'(e.se));
        chk({e.tag, ".irq"},   24'(alm_irq),      24'(e.irq));
        chk({e.tag, ".ready"}, 24'(set_ready),    24'(e.rdy));
    endtask

    task automatic steps(input int n, input string tag, input logic [23:0] t,
                         input logic [1:0] irq);
        for (int k = 0; k < n; k++) step(tag, t, 1'b0, 1'b0, irq, 1'b1);
    endtask

    initial begin
        // reset state
        step("rst0", 24'h000000, 1'b0, 1'b0, 2'b00, 1'b0);
        step("rst1", 24'h000000, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
        step("idle", 24'h000000, 1'b0, 1'b0, 2'b00, 1'b1);

        // rollover 23:59:58 -> 00:00:00 over two ticks
        set_valid = 1'b1; set_time = 24'h235958;
        step("ld_roll", 24'h235958, 1'b0, 1'b0, 2'b00, 1'b1);
        set_valid = 1'b0; run = 1'b1;
        steps(3, "roll_a", 24'h235958, 2'b00);
        step("roll_t1", 24'h235959, 1'b1, 1'b0, 2'b00, 1'b1);
        steps(3, "roll_b", 24'h235959, 2'b00);
        step("roll_t2", 24'h000000, 1'b1, 1'b0, 2'b00, 1'b1);

        // pause mid-second: prescaler holds, then resumes where it stopped
        steps(2, "pre_pause", 24'h000000, 2'b00);
        run = 1'b0;
        steps(10, "pause", 24'h000000, 2'b00);
        run = 1'b1;
        step("resume", 24'h000000, 1'b0, 1'b0, 2'b00, 1'b1);
        step("resume_t", 24'h000001, 1'b1, 1'b0, 2'b00, 1'b1);

        // invalid loads
        run = 1'b0;
        set_valid = 1'b1; set_time = 24'h126000;
        step("bad_min", 24'h000001, 1'b0, 1'b1, 2'b00, 1'b1);
        set_valid = 1'b0;
        step("bad_min_clr", 24'h000001, 1'b0, 1'b0, 2'b00, 1'b1);
        set_valid = 1'b1; set_time = 24'h125A00;
        step("bad_nib", 24'h000001, 1'b0, 1'b1, 2'b00, 1'b1);
        set_time = 24'h240000;
        step("bad_hr", 24'h000001, 1'b0, 1'b1, 2'b00, 1'b1);
        set_valid = 1'b0;
        step("bad_clr", 24'h000001, 1'b0, 1'b0, 2'b00, 1'b1);

        // load coinciding with a tick wins and restarts the prescaler
        run = 1'b1;
        steps(3, "pre_sim", 24'h000001, 2'b00);
        set_valid = 1'b1; set_time = 24'h101010;
        step("sim_load", 24'h101010, 1'b0, 1'b0, 2'b00, 1'b1);
        set_valid = 1'b0;
        steps(3, "sim_wait", 24'h101010, 2'b00);
        step("sim_t", 24'h101011, 1'b1, 1'b0, 2'b00, 1'b1);

        // channel 1 alarm at 07:30, sticky until ack
        run = 1'b0;
        alm_wr = 1'b1; alm_idx = 1'b1; alm_time = 16'h0730; alm_arm = 1'b1;
        step("wr_ch1", 24'h101011, 1'b0, 1'b0, 2'b00, 1'b1);
        alm_wr = 1'b0;
        set_valid = 1'b1; set_time = 24'h072959;
        step("ld_0729", 24'h072959, 1'b0, 1'b0, 2'b00, 1'b1);
        set_valid = 1'b0; run = 1'b1;
        steps(3, "alm_wait", 24'h072959, 2'b00);
        step("alm_fire", 24'h073000, 1'b1, 1'b0, 2'b10, 1'b1);
        run = 1'b0;
        steps(3, "alm_hold", 24'h073000, 2'b10);
        alm_ack = 2'b10;
        step("alm_ack", 24'h073000, 1'b0, 1'b0, 2'b00, 1'b1);
        alm_ack = 2'b00;

        // a load landing exactly on the alarm minute does not fire
        set_valid = 1'b1; set_time = 24'h073000;
        step("ld_exact", 24'h073000, 1'b0, 1'b0, 2'b00, 1'b1);

        // re-fire, then a rewrite of the channel clears the request
        set_time = 24'h072959;
        step("ld2", 24'h072959, 1'b0, 1'b0, 2'b00, 1'b1);
        set_valid = 1'b0; run = 1'b1;
        steps(3, "alm2_wait", 24'h072959, 2'b00);
        step("alm2_fire", 24'h073000, 1'b1, 1'b0, 2'b10, 1'b1);
        run = 1'b0;
        alm_wr = 1'b1; alm_idx = 1'b1; alm_time = 16'h0000; alm_arm = 1'b1;
        step("rewrite", 24'h073000, 1'b0, 1'b0, 2'b00, 1'b1);

        // invalid alarm value is dropped with an error pulse
        alm_idx = 1'b0; alm_time = 16'h0A00;
        step("bad_alm", 24'h073000, 1'b0, 1'b1, 2'b00, 1'b1);

        // channel 0 alarm set and ack in the same cycle: set wins
        alm_time = 16'h0800;
        step("wr_ch0", 24'h073000, 1'b0, 1'b0, 2'b00, 1'b1);
        alm_wr = 1'b0;
        set_valid = 1'b1; set_time = 24'h075959;
        step("ld_0759", 24'h075959, 1'b0, 1'b0, 2'b00, 1'b1);
        set_valid = 1'b0; run = 1'b1;
        steps(3, "ack_wait", 24'h075959, 2'b00);
        alm_ack = 2'b01;
        step("set_ack", 24'h080000, 1'b1, 1'b0, 2'b01, 1'b1);
        alm_ack = 2'b00;
        step("set_ack_hold", 24'h080000, 1'b0, 1'b0, 2'b01, 1'b1);

        // reset mid-count and mid-alarm abandons everything
        rst_n = 1'b0;
        step("rst_mid", 24'h000000, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
        steps(3, "post_rst", 24'h000000, 2'b00);
        step("post_rst_t", 24'h000001, 1'b1, 1'b0, 2'b00, 1'b1);

        // channel 1 (armed at 00:00 before reset) must now be disarmed
        run = 1'b0;
        set_valid = 1'b1; set_time = 24'h235959;
        step("ld_2359", 24'h235959, 1'b0, 1'b0, 2'b00, 1'b1);
        set_valid = 1'b0; run = 1'b1;
        steps(3, "mid_wait", 24'h235959, 2'b00);
        step("mid_t", 24'h000000, 1'b1, 1'b0, 2'b00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
